sd_cmd_response_receiver: RTL

Serial-to-parallel receiver for the SD CMD line, sitting directly downstream of the pad and upstream of the physical-layer command controller. While the controller holds it enabled during response wait, it:
- hunts for the start bit,
- shifts in a 48-bit card response frame,
- checks the framing bits and CRC7,
- presents the 38-bit index+argument payload with a completion flag.

If no start bit arrives within the response window, it reports no-response instead.

---
 rtl/sd_cmd_response_receiver.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sd_cmd_response_receiver.sv
// SD CMD-line response receiver: start-bit hunt, 48-bit frame capture, CRC7/framing check.
// Results register on the end-bit edge and hold until the controller drops iEnable.
module sd_cmd_response_receiver #(
   parameter int NCR_MAX = 56
) (
   input  logic        iClock_SD,
   input  logic        iReset_n,
   input  logic        iEnable,
   input  logic        iCmd_in,
   output logic        oReception_complete,
   output logic        oNo_response,
   output logic [37:0] oResponse,
   output logic        oCrc_error,
   output logic        oFrame_error,
   output logic        oBusy
);

   localparam int         FRAME_BITS = 48;
   localparam logic [5:0] NCR_SAT    = 6'(NCR_MAX);
   localparam logic [5:0] NCR_LAST   = 6'(NCR_MAX - 1);
   localparam logic [5:0] BIT_FIRST  = 6'(FRAME_BITS - 2);
   localparam logic [5:0] CRC_LAST   = 6'd8;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      RECEIVE,
      DONE,
      NO_RESP
   } state_t;

   state_t                  state, state_nxt;
   logic [5:0]              wait_cnt, wait_cnt_nxt;
   logic [5:0]              bit_cnt, bit_cnt_nxt;
   logic [FRAME_BITS-2:0]   shift, shift_nxt;
   logic [6:0]              crc, crc_nxt;
   logic [FRAME_BITS-1:0]   frame;
   logic                    complete_nxt, no_resp_nxt, crc_err_nxt, frame_err_nxt;
   logic [37:0]             response_nxt;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // Full frame as seen on the end-bit edge: stored bits 47..1 plus the live end bit.
   assign frame = {shift, iCmd_in};
   assign oBusy = (state == RECEIVE);

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift;
      crc_nxt       = crc;
      complete_nxt  = oReception_complete;
      no_resp_nxt   = oNo_response;
      crc_err_nxt   = oCrc_error;
      frame_err_nxt = oFrame_error;
      response_nxt  = oResponse;

      case (state)
         IDLE: begin
            wait_cnt_nxt  = '0;
            bit_cnt_nxt   = '0;
            crc_nxt       = '0;
            complete_nxt  = 1'b0;
            no_resp_nxt   = 1'b0;
            crc_err_nxt   = 1'b0;
            frame_err_nxt = 1'b0;
            state_nxt     = WAIT_START;
         end
         WAIT_START: begin
            if (!iCmd_in) begin
               state_nxt   = RECEIVE;
               bit_cnt_nxt = BIT_FIRST;
               crc_nxt     = crc7_step(crc, iCmd_in);
               shift_nxt   = {shift[FRAME_BITS-3:0], iCmd_in};
            end else begin
               if (wait_cnt < NCR_SAT) wait_cnt_nxt = wait_cnt + 6'd1;
               if (wait_cnt >= NCR_LAST) begin
                  state_nxt   = NO_RESP;
                  no_resp_nxt = 1'b1;
               end
            end
         end
         RECEIVE: begin
            shift_nxt   = {shift[FRAME_BITS-3:0], iCmd_in};
            bit_cnt_nxt = (bit_cnt != 6'd0) ? bit_cnt - 6'd1 : 6'd0;
            if (bit_cnt >= CRC_LAST) crc_nxt = crc7_step(crc, iCmd_in);
            if (bit_cnt == 6'd0) begin
               state_nxt     = DONE;
               response_nxt  = frame[45:8];
               crc_err_nxt   = (crc != frame[7:1]);
               // frame[47] is the start bit and always 0 here; kept for a complete layout check.
               frame_err_nxt = frame[47] | frame[46] | ~frame[0];
               complete_nxt  = 1'b1;
            end
         end
         default: ;
      endcase

      if (!iEnable) begin
         state_nxt     = IDLE;
         complete_nxt  = 1'b0;
         no_resp_nxt   = 1'b0;
         crc_err_nxt   = 1'b0;
         frame_err_nxt = 1'b0;
      end
   end

   always_ff @(posedge iClock_SD or negedge iReset_n) begin
      if (!iReset_n) begin
         state               <= IDLE;
         wait_cnt            <= '0;
         bit_cnt             <= '0;
         shift               <= '0;
         crc                 <= '0;
         oReception_complete <= 1'b0;
         oNo_response        <= 1'b0;
         oCrc_error          <= 1'b0;
         oFrame_error        <= 1'b0;
         oResponse           <= '0;
      end else begin
         state               <= state_nxt;
         wait_cnt            <= wait_cnt_nxt;
         bit_cnt             <= bit_cnt_nxt;
         shift               <= shift_nxt;
         crc                 <= crc_nxt;
         oReception_complete <= complete_nxt;
         oNo_response        <= no_resp_nxt;
         oCrc_error          <= crc_err_nxt;
         oFrame_error        <= frame_err_nxt;
         oResponse           <= response_nxt;
      end
   end

endmodule
